// File: rtl/error_report_parser_if.sv
// Byte-in / record-out bundle for the UART error-report parser.
// The master side feeds bytes and accepts records; the slave side is the parser.
interface error_report_parser_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 1
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  report_valid;
  logic                  report_ready;
  logic                  report_kind;
  logic [7:0]            error_state;
  logic [ADDR_WIDTH-1:0] error_address;
  logic [DATA_WIDTH-1:0] expected_data;
  logic [DATA_WIDTH-1:0] actual_data;
  logic [23:0]           loop_info;
  logic                  frame_error;
  logic [7:0]            drop_count;

  modport master (
    output rx_data, rx_valid, report_ready,
    input  rx_ready, report_valid, report_kind, error_state, error_address,
           expected_data, actual_data, loop_info, frame_error, drop_count
  );

  modport slave (
    input  rx_data, rx_valid, report_ready,
    output rx_ready, report_valid, report_kind, error_state, error_address,
           expected_data, actual_data, loop_info, frame_error, drop_count
  );
endinterface

// File: rtl/error_report_parser.sv
// Parses 'L' (loop-complete) and 'E' (error) frames from a UART byte stream
// and presents each well-formed frame as one record on a valid/ready port.
module error_report_parser #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  error_report_parser_if.slave bus
);

  localparam int AB = (ADDR_WIDTH + 7) / 8;
  localparam int DB = (DATA_WIDTH + 7) / 8;
  localparam logic [7:0] AB_LAST = 8'(AB - 1);
  localparam logic [7:0] DB_LAST = 8'(DB - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_L_PAY, S_E_STATE, S_E_ADDR, S_E_EXP, S_E_ACT, S_CR, S_LF, S_OUT
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  report_valid_q, report_valid_d;
  logic                  frame_error_q, frame_error_d;
  logic [7:0]            drop_q, drop_d;
  logic                  kind_q, kind_d;
  logic [7:0]            err_state_q, err_state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [DATA_WIDTH-1:0] act_q, act_d;
  logic [23:0]           loop_q, loop_d;
  logic                  rx_fire_s;
  logic                  rep_fire_s;

  assign rx_fire_s  = bus.rx_valid & rx_ready_q;
  assign rep_fire_s = report_valid_q & bus.report_ready;

  // Next-state, byte-field capture and status computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    frame_error_d = 1'b0;
    drop_d        = drop_q;
    kind_d        = kind_q;
    err_state_d   = err_state_q;
    addr_d        = addr_q;
    exp_d         = exp_q;
    act_d         = act_q;
    loop_d        = loop_q;

    case (state_q)
      S_IDLE: begin
        if (rx_fire_s) begin
          if (bus.rx_data == 8'h4C) begin
            state_d = S_L_PAY;
            kind_d  = 1'b0;
          end else if (bus.rx_data == 8'h45) begin
            state_d = S_E_STATE;
            kind_d  = 1'b1;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end else begin
            drop_d = drop_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_L_PAY: begin
        if (rx_fire_s) begin
          for (int i = 0; i < 24; i++) begin
            if ((i / 8) == int'(cnt_q)) loop_d[i] = bus.rx_data[i % 8];
            else                        loop_d[i] = loop_q[i];
          end
          if (cnt_q == 8'd2) state_d = S_CR;
          else               state_d = S_L_PAY;
        end else begin
          state_d = S_L_PAY;
        end
      end
      S_E_STATE: begin
        if (rx_fire_s) begin
          err_state_d = bus.rx_data;
          state_d     = S_E_ADDR;
        end else begin
          state_d = S_E_STATE;
        end
      end
      S_E_ADDR: begin
        if (rx_fire_s) begin
          // Bits beyond ADDR_WIDTH in the top byte simply have no destination.
          for (int i = 0; i < ADDR_WIDTH; i++) begin
            if ((i / 8) == int'(cnt_q)) addr_d[i] = bus.rx_data[i % 8];
            else                        addr_d[i] = addr_q[i];
          end
          if (cnt_q == AB_LAST) state_d = S_E_EXP;
          else                  state_d = S_E_ADDR;
        end else begin
          state_d = S_E_ADDR;
        end
      end
      S_E_EXP: begin
        if (rx_fire_s) begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if ((i / 8) == int'(cnt_q)) exp_d[i] = bus.rx_data[i % 8];
            else                        exp_d[i] = exp_q[i];
          end
          if (cnt_q == DB_LAST) state_d = S_E_ACT;
          else                  state_d = S_E_EXP;
        end else begin
          state_d = S_E_EXP;
        end
      end
      S_E_ACT: begin
        if (rx_fire_s) begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if ((i / 8) == int'(cnt_q)) act_d[i] = bus.rx_data[i % 8];
            else                        act_d[i] = act_q[i];
          end
          if (cnt_q == DB_LAST) state_d = S_CR;
          else                  state_d = S_E_ACT;
        end else begin
          state_d = S_E_ACT;
        end
      end
      S_CR: begin
        if (rx_fire_s) begin
          if (bus.rx_data == 8'h0D) begin
            state_d = S_LF;
          end else begin
            frame_error_d = 1'b1;
            state_d       = S_IDLE;
          end
        end else begin
          state_d = S_CR;
        end
      end
      S_LF: begin
        if (rx_fire_s) begin
          if (bus.rx_data == 8'h0A) begin
            state_d = S_OUT;
          end else begin
            frame_error_d = 1'b1;
            state_d       = S_IDLE;
          end
        end else begin
          state_d = S_LF;
        end
      end
      S_OUT: begin
        if (rep_fire_s) state_d = S_IDLE;
        else            state_d = S_OUT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Byte counter restarts on every state entry and only advances in byte-field states.
    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if (rx_fire_s && (state_q != S_IDLE)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end

    rx_ready_d     = (state_d != S_OUT);
    report_valid_d = (state_d == S_OUT);
  end

  // State, handshake and record registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= 8'd0;
      rx_ready_q     <= 1'b1;
      report_valid_q <= 1'b0;
      frame_error_q  <= 1'b0;
      drop_q         <= 8'd0;
      kind_q         <= 1'b0;
      err_state_q    <= 8'd0;
      addr_q         <= '0;
      exp_q          <= '0;
      act_q          <= '0;
      loop_q         <= 24'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rx_ready_q     <= rx_ready_d;
      report_valid_q <= report_valid_d;
      frame_error_q  <= frame_error_d;
      drop_q         <= drop_d;
      kind_q         <= kind_d;
      err_state_q    <= err_state_d;
      addr_q         <= addr_d;
      exp_q          <= exp_d;
      act_q          <= act_d;
      loop_q         <= loop_d;
    end
  end

  assign bus.rx_ready      = rx_ready_q;
  assign bus.report_valid  = report_valid_q;
  assign bus.report_kind   = kind_q;
  assign bus.error_state   = err_state_q;
  assign bus.error_address = addr_q;
  assign bus.expected_data = exp_q;
  assign bus.actual_data   = act_q;
  assign bus.loop_info     = loop_q;
  assign bus.frame_error   = frame_error_q;
  assign bus.drop_count    = drop_q;

endmodule

// File: tb/tb_error_report_parser.sv
// Self-checking bench for error_report_parser: frame table plus hand-written
// backpressure, bad-terminator, reset and saturation sequences.
module tb_error_report_parser;

  logic clk;
  logic rst_n;

  error_report_parser_if #(.ADDR_WIDTH(10), .DATA_WIDTH(1)) bus ();

  error_report_parser #(.ADDR_WIDTH(10), .DATA_WIDTH(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        kind;
    logic [7:0]  st;
    logic [9:0]  addr;
    logic        ed;
    logic        ad;
    logic [23:0] loop;
  } rec_t;

  typedef struct {
    logic [7:0] b [8];
    int         n;
    rec_t       exp;
  } vec_t;

  rec_t exp_q[$];
  rec_t mon_e;
  vec_t vt [5];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   fe_cnt = 0;
  int   fe_base;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Scoreboard: pop an expected record on every report handshake.
  always @(negedge clk) begin
    if (rst_n && bus.report_valid && bus.report_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_report", 32'(bus.report_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("report_kind",   32'(bus.report_kind),   32'(mon_e.kind));
        chk("error_state",   32'(bus.error_state),   32'(mon_e.st));
        chk("error_address", 32'(bus.error_address), 32'(mon_e.addr));
        chk("expected_data", 32'(bus.expected_data), 32'(mon_e.ed));
        chk("actual_data",   32'(bus.actual_data),   32'(mon_e.ad));
        chk("loop_info",     32'(bus.loop_info),     32'(mon_e.loop));
      end
    end
    if (rst_n && bus.frame_error) fe_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    exp_q.push_back(v.exp);
    for (int k = 0; k < v.n; k++) send_byte(v.b[k]);
    chk({tag, "_valid_after_lf"}, 32'(bus.report_valid), 32'd1);
    chk({tag, "_rx_ready_in_out"}, 32'(bus.rx_ready), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rx_ready"},     32'(bus.rx_ready),      32'd1);
    chk({tag, "_report_valid"}, 32'(bus.report_valid),  32'd0);
    chk({tag, "_frame_error"},  32'(bus.frame_error),   32'd0);
    chk({tag, "_drop_count"},   32'(bus.drop_count),    32'd0);
    chk({tag, "_kind"},         32'(bus.report_kind),   32'd0);
    chk({tag, "_state"},        32'(bus.error_state),   32'd0);
    chk({tag, "_addr"},         32'(bus.error_address), 32'd0);
    chk({tag, "_exp"},          32'(bus.expected_data), 32'd0);
    chk({tag, "_act"},          32'(bus.actual_data),   32'd0);
    chk({tag, "_loop"},         32'(bus.loop_info),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst_n            = 1'b0;
    bus.rx_valid     = 1'b0;
    bus.rx_data      = 8'h00;
    bus.report_ready = 1'b1;

    // Fields not carried by a frame kind keep the values of earlier frames.
    vt[0].b = '{8'h4C, 8'h01, 8'h02, 8'h03, 8'h0D, 8'h0A, 8'h00, 8'h00}; vt[0].n = 6;
    vt[0].exp = '{kind: 1'b0, st: 8'h00, addr: 10'h000, ed: 1'b0, ad: 1'b0, loop: 24'h030201};
    vt[1].b = '{8'h45, 8'h02, 8'hEF, 8'h03, 8'h01, 8'h00, 8'h0D, 8'h0A}; vt[1].n = 8;
    vt[1].exp = '{kind: 1'b1, st: 8'h02, addr: 10'h3EF, ed: 1'b1, ad: 1'b0, loop: 24'h030201};
    vt[2].b = '{8'h4C, 8'hAA, 8'hBB, 8'hCC, 8'h0D, 8'h0A, 8'h00, 8'h00}; vt[2].n = 6;
    vt[2].exp = '{kind: 1'b0, st: 8'h02, addr: 10'h3EF, ed: 1'b1, ad: 1'b0, loop: 24'hCCBBAA};
    vt[3].b = '{8'h45, 8'h7F, 8'h34, 8'hFE, 8'hFE, 8'h03, 8'h0D, 8'h0A}; vt[3].n = 8;
    vt[3].exp = '{kind: 1'b1, st: 8'h7F, addr: 10'h234, ed: 1'b0, ad: 1'b1, loop: 24'hCCBBAA};
    vt[4].b = '{8'h4C, 8'h00, 8'hFF, 8'h80, 8'h0D, 8'h0A, 8'h00, 8'h00}; vt[4].n = 6;
    vt[4].exp = '{kind: 1'b0, st: 8'h7F, addr: 10'h234, ed: 1'b0, ad: 1'b1, loop: 24'h80FF00};

    #12;
    check_reset("reset_held");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset("reset_released");

    for (int i = 0; i < 5; i++) run_frame(vt[i], $sformatf("vec%0d", i));
    repeat (2) @(posedge clk);
    #1;
    chk("clean_frames_no_frame_error", 32'(fe_cnt), 32'd0);

    // Backpressure: record held while report_ready is low, next 'L' waits.
    bus.report_ready = 1'b0;
    v = vt[1];
    v.exp = '{kind: 1'b1, st: 8'h02, addr: 10'h3EF, ed: 1'b1, ad: 1'b0, loop: 24'h80FF00};
    exp_q.push_back(v.exp);
    for (int k = 0; k < v.n; k++) send_byte(v.b[k]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_held",    32'(bus.report_valid),  32'd1);
      chk("bp_rx_ready_low",  32'(bus.rx_ready),      32'd0);
      chk("bp_addr_held",     32'(bus.error_address), 32'h3EF);
      chk("bp_state_held",    32'(bus.error_state),   32'h02);
      if (i == 0) begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h4C;
      end
    end
    @(posedge clk); #1;
    bus.report_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_dropped", 32'(bus.report_valid), 32'd0);
    chk("bp_rx_ready_back", 32'(bus.rx_ready),     32'd1);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    exp_q.push_back('{kind: 1'b0, st: 8'h02, addr: 10'h3EF, ed: 1'b1, ad: 1'b0, loop: 24'h030201});
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h0D); send_byte(8'h0A);
    chk("bp_followup_valid", 32'(bus.report_valid), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_no_frame_error", 32'(fe_cnt), 32'd0);

    // Garbage bytes, then bad LF and bad CR terminators.
    send_byte(8'h58); send_byte(8'h00);
    chk("drop_count_two", 32'(bus.drop_count), 32'd2);
    fe_base = fe_cnt;
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h0D); send_byte(8'h41);
    chk("bad_lf_pulse",      32'(bus.frame_error),  32'd1);
    chk("bad_lf_no_valid",   32'(bus.report_valid), 32'd0);
    @(posedge clk); #1;
    chk("bad_lf_pulse_end",  32'(bus.frame_error),  32'd0);
    send_byte(8'h4C); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h99);
    chk("bad_cr_pulse",      32'(bus.frame_error),  32'd1);
    chk("bad_byte_not_drop", 32'(bus.drop_count),   32'd2);
    v = vt[0];
    v.b[1] = 8'h11; v.b[2] = 8'h22; v.b[3] = 8'h33;
    v.exp = '{kind: 1'b0, st: 8'h02, addr: 10'h3EF, ed: 1'b1, ad: 1'b0, loop: 24'h332211};
    run_frame(v, "after_abort");
    repeat (2) @(posedge clk);
    #1;
    chk("frame_error_pulses", 32'(fe_cnt - fe_base), 32'd2);

    // Reset in the middle of an E frame.
    send_byte(8'h45); send_byte(8'h02); send_byte(8'hEF);
    rst_n = 1'b0;
    #2;
    check_reset("mid_frame_reset");
    @(negedge clk);
    rst_n = 1'b1;
    v = vt[0];
    v.exp = '{kind: 1'b0, st: 8'h00, addr: 10'h000, ed: 1'b0, ad: 1'b0, loop: 24'h030201};
    run_frame(v, "post_reset");

    // drop_count saturation.
    for (int i = 0; i < 300; i++) send_byte(8'h20 + 8'(i % 16));
    chk("drop_count_saturated", 32'(bus.drop_count), 32'd255);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
